// File: rtl/uart_pkg.sv
// Shared definitions for the firmware console UART: frame geometry and FSM states.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with combinational head read; a push into a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is implicit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/out_byte_uart_tx.sv
// Console UART transmitter: buffers firmware out_byte writes and sends them
// as 8N1 frames with back-to-back framing when data is waiting.
module out_byte_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_byte,
    input  logic       in_byte_en,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    DATA_LAST = 3'(UART_DATA_BITS - 1);

    uart_state_t    state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_d;
    logic           bit_end;
    logic           pop;
    logic           push_ok;
    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  count_next;
    logic           fifo_empty;

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_byte_en),
        .din   (in_byte),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Mirrors the FIFO acceptance rule so busy can be formed from next-cycle count.
    assign push_ok    = in_byte_en && (!fifo_full || pop);
    assign count_next = fifo_count + CW'(push_ok) - CW'(pop);
    assign bit_end    = (timer_q == BIT_LAST);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_d = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == DATA_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the next state so the line changes on state entry.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
            busy    <= (count_next != '0) || (state_d != IDLE);
            if (in_byte_en && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_byte_uart_tx.sv
// Directed bench for out_byte_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_out_byte_uart_tx;

    logic       clk;
    logic       reset;
    logic [7:0] in_byte;
    logic       in_byte_en;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    int unsigned n_pass;
    int unsigned n_total;

    out_byte_uart_tx #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_byte    (in_byte),
        .in_byte_en (in_byte_en),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        in_byte    = b;
        in_byte_en = 1'b1;
        tick(1);
        in_byte_en = 1'b0;
    endtask

    task automatic do_reset();
        in_byte_en = 1'b0;
        reset      = 1'b1;
        tick(2);
        reset      = 1'b0;
    endtask

    // Called 'phase' cycles after the edge that started the start bit; samples
    // every not-yet-passed bit centre and returns 40 cycles after that edge.
    task automatic expect_frame(input logic [7:0] b, input int unsigned phase, input string tag);
        logic [9:0]  frame;
        int unsigned ph;
        int unsigned c;
        frame = {1'b1, b, 1'b0};
        ph    = phase;
        for (int unsigned k = 0; k < 10; k++) begin
            c = 4 * k + 2;
            if (c >= ph) begin
                tick(c - ph);
                ph = c;
                check($sformatf("%s_bit%0d", tag, k), 32'(tx), 32'(frame[k]));
            end
        end
        tick(40 - ph);
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        in_byte    = 8'h00;
        in_byte_en = 1'b0;
        reset      = 1'b1;

        // Reset and idle
        do_reset();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 50; i++) begin
            check("idle", {28'd0, tx, busy, fifo_full, overflow}, 32'h8);
            tick(1);
        end

        // Single frame 0x55
        push(8'h55);
        check("w55_busy", 32'(busy), 32'd1);
        check("w55_tx_e0", 32'(tx), 32'd1);
        tick(1);
        check("w55_tx_e1", 32'(tx), 32'd0);
        expect_frame(8'h55, 0, "f55");
        check("w55_busy_end", 32'(busy), 32'd0);
        check("w55_tx_end", 32'(tx), 32'd1);
        tick(5);

        // Three back-to-back frames
        push(8'h41);
        push(8'h42);
        check("b2b_start", 32'(tx), 32'd0);
        push(8'h0A);
        expect_frame(8'h41, 1, "f41");
        check("b2b_gap1", 32'(tx), 32'd0);
        expect_frame(8'h42, 0, "f42");
        check("b2b_gap2", 32'(tx), 32'd0);
        expect_frame(8'h0A, 0, "f0a");
        check("b2b_busy_end", 32'(busy), 32'd0);
        check("b2b_tx_end", 32'(tx), 32'd1);
        tick(5);

        // Overflow: 6 writes, 0x06 dropped
        do_reset();
        push(8'h01);
        check("ov_full_e0", 32'(fifo_full), 32'd0);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        check("ov_full_e3", 32'(fifo_full), 32'd0);
        push(8'h05);
        check("ov_full_e4", 32'(fifo_full), 32'd1);
        check("ov_ovf_e4", 32'(overflow), 32'd0);
        push(8'h06);
        check("ov_full_e5", 32'(fifo_full), 32'd1);
        check("ov_ovf_e5", 32'(overflow), 32'd1);
        expect_frame(8'h01, 4, "fo1");
        check("ov_full_e41", 32'(fifo_full), 32'd0);
        check("ov_gap1", 32'(tx), 32'd0);
        expect_frame(8'h02, 0, "fo2");
        check("ov_gap2", 32'(tx), 32'd0);
        expect_frame(8'h03, 0, "fo3");
        check("ov_gap3", 32'(tx), 32'd0);
        expect_frame(8'h04, 0, "fo4");
        check("ov_gap4", 32'(tx), 32'd0);
        expect_frame(8'h05, 0, "fo5");
        check("ov_busy_end", 32'(busy), 32'd0);
        check("ov_tx_end", 32'(tx), 32'd1);
        tick(10);
        check("ov_sticky", 32'(overflow), 32'd1);
        check("ov_no_more", 32'(tx), 32'd1);

        // Write into full FIFO on the same edge as a pop
        do_reset();
        check("fp_ovf_rst", 32'(overflow), 32'd0);
        push(8'hA0);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        push(8'hA4);
        check("fp_full_e4", 32'(fifo_full), 32'd1);
        tick(36);
        check("fp_full_e40", 32'(fifo_full), 32'd1);
        push(8'h99);
        check("fp_full_e41", 32'(fifo_full), 32'd1);
        check("fp_ovf_e41", 32'(overflow), 32'd0);
        check("fp_tx_e41", 32'(tx), 32'd0);
        expect_frame(8'hA1, 0, "fa1");
        expect_frame(8'hA2, 0, "fa2");
        expect_frame(8'hA3, 0, "fa3");
        expect_frame(8'hA4, 0, "fa4");
        check("fp_gap", 32'(tx), 32'd0);
        expect_frame(8'h99, 0, "f99");
        check("fp_busy_end", 32'(busy), 32'd0);
        check("fp_ovf_end", 32'(overflow), 32'd0);
        tick(5);

        // Reset mid-DATA truncates the frame
        push(8'hF0);
        tick(1);
        check("rm_start", 32'(tx), 32'd0);
        tick(10);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rm_tx", 32'(tx), 32'd1);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_full", 32'(fifo_full), 32'd0);
        for (int i = 0; i < 30; i++) begin
            tick(1);
            check("rm_quiet", {30'd0, tx, busy}, 32'h2);
        end
        push(8'h33);
        check("rm_w33_busy", 32'(busy), 32'd1);
        tick(1);
        check("rm_w33_start", 32'(tx), 32'd0);
        expect_frame(8'h33, 0, "f33");
        check("rm_busy_end", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
